pma_region_table: RTL and testbench
===================================

Name: pma_region_table

Overview:
- Runtime-programmable physical-memory-attribute table, generalising the static execute/cached/non-idempotent region rules fixed at elaboration time.
- Holds NrRegions base/length/attribute entries, each writable through a simple config port, with per-entry lock.
- Answers address lookups through a 2-stage valid/ready pipeline.
- Sits beside the MMU/LSU and frontend. Reports whether a physical address is executable, cacheable or non-idempotent, and which region matched.

Parameters:
- NrRegions, 8, number of table entries (2..16)
- PlenWidth, 34, physical address / length width
- IdxWidth, $clog2(NrRegions), region index width
- ResetBase, {0x8000_0000, 0x1_0000, 0x0, 0...}, packed NrRegions*PlenWidth reset bases (entry 0 = DRAM, 1 = boot ROM, 2 = debug module)
- ResetLen, {0x4000_0000, 0x1_0000, 0x1000, 0...}, packed reset lengths
- ResetAttr, {4'b0011, 4'b0001, 4'b0101, 0...}, packed 4-bit reset attributes

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cfg_req_i  in  1  config access request
- cfg_we_i  in  1  1 = write, 0 = read
- cfg_idx_i  in  4  entry index
- cfg_sel_i  in  2  field: 0 = base, 1 = length, 2 = attr, 3 = reserved
- cfg_wdata_i  in  PlenWidth  write data (attr uses bits [3:0])
- cfg_ack_o  out  1  access complete
- cfg_err_o  out  1  access rejected; qualified by cfg_ack_o
- cfg_rdata_o  out  PlenWidth  read data; qualified by cfg_ack_o
- lu_valid_i  in  1  lookup request valid
- lu_ready_o  out  1  lookup request accepted
- lu_addr_i  in  PlenWidth  physical address to classify
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumed
- res_hit_o  out  1  some enabled region matched
- res_region_o  out  IdxWidth  matching region index
- res_exec_o  out  1  executable
- res_cached_o  out  1  cacheable
- res_nonidem_o  out  1  non-idempotent

Behaviour:
- Attribute encoding: attr[0] X, attr[1] C, attr[2] NI, attr[3] L (lock).
- Region i matches when len_i != 0 and base_i <= addr < base_i + len_i.
  - Sum is computed in PlenWidth+1 bits, so a region reaching the top of the space does not wrap.
  - len = 0 disables the entry.
- Multiple matches: lowest index wins.
- No match: res_hit_o = 0, res_region_o = 0, all attribute outputs 0.
- Reset (asynchronous, any time):
  - Table loads ResetBase/ResetLen/ResetAttr.
  - Both pipeline valid bits clear, cfg_ack_o = 0, cfg_err_o = 0, cfg_rdata_o = 0, res_* = 0.
  - Any in-flight lookup or config access is dropped.
- Config port:
  - A request sampled at edge N produces cfg_ack_o = 1 for exactly the cycle after N. Back-to-back requests every cycle are legal.
  - Error when cfg_idx_i >= NrRegions, cfg_sel_i = 3, or a write targets an entry whose L = 1.
  - On error: no state change, cfg_rdata_o = 0.
  - Writes commit at edge N.
  - Writing attr with bit 3 = 1 sets the lock. The lock is only cleared by reset, and a locked entry rejects all three fields.
  - Reads return the zero-extended field.
- Lookup pipeline, stage 1 (S1):
  - Registers the per-region hit vector and per-region attrs, using table contents before edge N.
  - A lookup accepted in the same cycle as a committing write sees the old entry.
- Lookup pipeline, stage 2 (S2):
  - Priority-encodes and registers the results.
  - Latency is 2 cycles from acceptance to res_valid_o with no backpressure. Throughput is 1 per cycle.
- Handshake:
  - s2_adv = !s2_valid | res_ready_i
  - lu_ready_o = !s1_valid | s2_adv (combinational, no dependence on lu_valid_i)
  - res_* stay stable while res_valid_o & !res_ready_i.
  - A later table write never alters an already-registered S1 or S2 result.
- No combinational path from lu_valid_i to res_valid_o, and none from cfg_req_i to cfg_ack_o.

Test Plan:
- Reset, lookup 0x8000_1000 -> 2 cycles later res_valid=1, hit=1, region=0, exec=1, cached=1, nonidem=0. Lookup 0x0000_0800 -> region=2, exec=1, nonidem=1. Lookup 0x2000_0000 -> hit=0, all attrs 0.
- Write entry 3 base=0x8000_0000, len=0x1000, attr=0b0100, then lookup 0x8000_0010 -> region=0 (lower index wins). Repeat after writing entry 0 len=0 -> region=3, nonidem=1, cached=0.
- Write entry 4 attr=0b1001, then write entry 4 base -> cfg_ack=1, cfg_err=1, readback of base unchanged. Read with idx=12 (NrRegions=8) -> err=1, rdata=0.
- Entry 5 base=0x3_FFFF_F000, len=0x1000, lookup 0x3_FFFF_FFFF -> hit region 5. Lookup 0x0 -> region 2 only, not 5 (no wrap).
- Stream 6 lookups back-to-back with res_ready_i low for cycles 3-6 -> lu_ready_o drops once both stages are full, results arrive in order, none lost or duplicated, outputs stable while stalled.
- Assert rst_i with both pipeline stages valid and a write pending -> res_valid_o=0 immediately. Table returns to reset values, and the pending write is not applied.

Source files
------------

// File: rtl/pma_region_table.sv
// Runtime-programmable physical memory attribute table: per-entry base/length/attr
// with sticky lock, a registered config port and a 2-stage valid/ready lookup pipeline.
module pma_region_table #(
    parameter int unsigned NrRegions = 8,
    parameter int unsigned PlenWidth = 34,
    parameter int unsigned IdxWidth  = $clog2(NrRegions),
    parameter logic [NrRegions*PlenWidth-1:0] ResetBase = (NrRegions*PlenWidth)'(
        {PlenWidth'(34'h0), PlenWidth'(34'h1_0000), PlenWidth'(34'h8000_0000)}),
    parameter logic [NrRegions*PlenWidth-1:0] ResetLen = (NrRegions*PlenWidth)'(
        {PlenWidth'(34'h1000), PlenWidth'(34'h1_0000), PlenWidth'(34'h4000_0000)}),
    parameter logic [NrRegions*4-1:0] ResetAttr = (NrRegions*4)'(
        {4'b0101, 4'b0001, 4'b0011})
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [3:0]           cfg_idx_i,
    input  logic [1:0]           cfg_sel_i,
    input  logic [PlenWidth-1:0] cfg_wdata_i,
    output logic                 cfg_ack_o,
    output logic                 cfg_err_o,
    output logic [PlenWidth-1:0] cfg_rdata_o,
    input  logic                 lu_valid_i,
    output logic                 lu_ready_o,
    input  logic [PlenWidth-1:0] lu_addr_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic                 res_hit_o,
    output logic [IdxWidth-1:0]  res_region_o,
    output logic                 res_exec_o,
    output logic                 res_cached_o,
    output logic                 res_nonidem_o
);

    localparam int unsigned AttrX  = 0;
    localparam int unsigned AttrC  = 1;
    localparam int unsigned AttrNi = 2;
    localparam int unsigned AttrL  = 3;

    logic [PlenWidth-1:0] base_q [NrRegions];
    logic [PlenWidth-1:0] base_d [NrRegions];
    logic [PlenWidth-1:0] len_q  [NrRegions];
    logic [PlenWidth-1:0] len_d  [NrRegions];
    logic [3:0]           attr_q [NrRegions];
    logic [3:0]           attr_d [NrRegions];

    logic                 idx_ok_s, locked_s, err_s, wr_en_s;
    logic [IdxWidth-1:0]  idx_s;
    logic                 cfg_ack_q, cfg_ack_d, cfg_err_q, cfg_err_d;
    logic [PlenWidth-1:0] cfg_rdata_q, cfg_rdata_d;

    logic                 s2_adv_s, lu_ready_s;
    logic [PlenWidth:0]   addr_ext_s;
    logic [NrRegions-1:0] hit_s, x_s, c_s, ni_s;
    logic                 s1_valid_q, s1_valid_d;
    logic [NrRegions-1:0] s1_hit_q, s1_hit_d, s1_x_q, s1_x_d, s1_c_q, s1_c_d, s1_ni_q, s1_ni_d;
    logic                 found_s, enc_x_s, enc_c_s, enc_ni_s;
    logic [IdxWidth-1:0]  enc_region_s;
    logic                 s2_valid_q, s2_valid_d;
    logic                 res_hit_q, res_hit_d, res_x_q, res_x_d, res_c_q, res_c_d;
    logic                 res_ni_q, res_ni_d;
    logic [IdxWidth-1:0]  res_region_q, res_region_d;

    // Decode a config access, build next table contents and the registered response.
    always_comb begin
        idx_ok_s = ({1'b0, cfg_idx_i} < 5'(NrRegions));
        idx_s    = cfg_idx_i[IdxWidth-1:0];
        if (idx_ok_s) begin
            locked_s = attr_q[idx_s][AttrL];
        end else begin
            locked_s = 1'b0;
        end
        err_s   = !idx_ok_s || (cfg_sel_i == 2'd3) || (cfg_we_i && locked_s);
        wr_en_s = cfg_req_i && cfg_we_i && !err_s;

        base_d = base_q;
        len_d  = len_q;
        attr_d = attr_q;
        if (wr_en_s) begin
            case (cfg_sel_i)
                2'd0:    base_d[idx_s] = cfg_wdata_i;
                2'd1:    len_d[idx_s]  = cfg_wdata_i;
                2'd2:    attr_d[idx_s] = cfg_wdata_i[3:0];
                default: attr_d = attr_q;
            endcase
        end else begin
            attr_d = attr_q;
        end

        cfg_ack_d   = cfg_req_i;
        cfg_err_d   = cfg_req_i && err_s;
        cfg_rdata_d = {PlenWidth{1'b0}};
        if (cfg_req_i && !cfg_we_i && !err_s) begin
            case (cfg_sel_i)
                2'd0:    cfg_rdata_d = base_q[idx_s];
                2'd1:    cfg_rdata_d = len_q[idx_s];
                2'd2:    cfg_rdata_d = {{(PlenWidth-4){1'b0}}, attr_q[idx_s]};
                default: cfg_rdata_d = {PlenWidth{1'b0}};
            endcase
        end else begin
            cfg_rdata_d = {PlenWidth{1'b0}};
        end
    end

    // Table storage and config response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NrRegions); i++) begin
                base_q[i] <= ResetBase[i*PlenWidth +: PlenWidth];
                len_q[i]  <= ResetLen[i*PlenWidth +: PlenWidth];
                attr_q[i] <= ResetAttr[i*4 +: 4];
            end
            cfg_ack_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_rdata_q <= {PlenWidth{1'b0}};
        end else begin
            base_q      <= base_d;
            len_q       <= len_d;
            attr_q      <= attr_d;
            cfg_ack_q   <= cfg_ack_d;
            cfg_err_q   <= cfg_err_d;
            cfg_rdata_q <= cfg_rdata_d;
        end
    end

    // Per-region range match; the end bound uses one extra bit so top-of-space regions do not wrap.
    always_comb begin
        addr_ext_s = {1'b0, lu_addr_i};
        for (int i = 0; i < int'(NrRegions); i++) begin
            hit_s[i] = (len_q[i] != {PlenWidth{1'b0}})
                    && (addr_ext_s >= {1'b0, base_q[i]})
                    && (addr_ext_s < ({1'b0, base_q[i]} + {1'b0, len_q[i]}));
            x_s[i]   = attr_q[i][AttrX];
            c_s[i]   = attr_q[i][AttrC];
            ni_s[i]  = attr_q[i][AttrNi];
        end
    end

    // Lowest matching index wins; no match leaves everything zero.
    always_comb begin
        found_s      = 1'b0;
        enc_region_s = {IdxWidth{1'b0}};
        enc_x_s      = 1'b0;
        enc_c_s      = 1'b0;
        enc_ni_s     = 1'b0;
        for (int i = 0; i < int'(NrRegions); i++) begin
            if (!found_s && s1_hit_q[i]) begin
                found_s      = 1'b1;
                enc_region_s = IdxWidth'(i);
                enc_x_s      = s1_x_q[i];
                enc_c_s      = s1_c_q[i];
                enc_ni_s     = s1_ni_q[i];
            end else begin
                found_s = found_s;
            end
        end
    end

    assign s2_adv_s   = !s2_valid_q || res_ready_i;
    assign lu_ready_s = !s1_valid_q || s2_adv_s;

    // Pipeline next state: S1 captures match vector, S2 captures the encoded result.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_hit_d     = s1_hit_q;
        s1_x_d       = s1_x_q;
        s1_c_d       = s1_c_q;
        s1_ni_d      = s1_ni_q;
        s2_valid_d   = s2_valid_q;
        res_hit_d    = res_hit_q;
        res_region_d = res_region_q;
        res_x_d      = res_x_q;
        res_c_d      = res_c_q;
        res_ni_d     = res_ni_q;
        if (lu_ready_s) begin
            s1_valid_d = lu_valid_i;
            if (lu_valid_i) begin
                s1_hit_d = hit_s;
                s1_x_d   = x_s;
                s1_c_d   = c_s;
                s1_ni_d  = ni_s;
            end else begin
                s1_hit_d = s1_hit_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_hit_d    = found_s;
                res_region_d = enc_region_s;
                res_x_d      = enc_x_s;
                res_c_d      = enc_c_s;
                res_ni_d     = enc_ni_s;
            end else begin
                res_hit_d = res_hit_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q   <= 1'b0;
            s1_hit_q     <= {NrRegions{1'b0}};
            s1_x_q       <= {NrRegions{1'b0}};
            s1_c_q       <= {NrRegions{1'b0}};
            s1_ni_q      <= {NrRegions{1'b0}};
            s2_valid_q   <= 1'b0;
            res_hit_q    <= 1'b0;
            res_region_q <= {IdxWidth{1'b0}};
            res_x_q      <= 1'b0;
            res_c_q      <= 1'b0;
            res_ni_q     <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_hit_q     <= s1_hit_d;
            s1_x_q       <= s1_x_d;
            s1_c_q       <= s1_c_d;
            s1_ni_q      <= s1_ni_d;
            s2_valid_q   <= s2_valid_d;
            res_hit_q    <= res_hit_d;
            res_region_q <= res_region_d;
            res_x_q      <= res_x_d;
            res_c_q      <= res_c_d;
            res_ni_q     <= res_ni_d;
        end
    end

    assign cfg_ack_o     = cfg_ack_q;
    assign cfg_err_o     = cfg_err_q;
    assign cfg_rdata_o   = cfg_rdata_q;
    assign lu_ready_o    = lu_ready_s;
    assign res_valid_o   = s2_valid_q;
    assign res_hit_o     = res_hit_q;
    assign res_region_o  = res_region_q;
    assign res_exec_o    = res_x_q;
    assign res_cached_o  = res_c_q;
    assign res_nonidem_o = res_ni_q;

endmodule

// File: tb/tb_pma_region_table.sv
// Randomised and directed bench for pma_region_table against an array-based region model.
module tb_pma_region_table;

    localparam int N  = 8;
    localparam int PW = 34;
    localparam int IW = 3;
    localparam longint unsigned MASK = 64'h3_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_req = 1'b0, cfg_we = 1'b0;
    logic [3:0]    cfg_idx = 4'd0;
    logic [1:0]    cfg_sel = 2'd0;
    logic [PW-1:0] cfg_wdata = '0;
    logic          cfg_ack, cfg_err;
    logic [PW-1:0] cfg_rdata;
    logic          lu_valid = 1'b0, lu_ready;
    logic [PW-1:0] lu_addr = '0;
    logic          res_valid, res_ready = 1'b1;
    logic          res_hit, res_exec, res_cached, res_nonidem;
    logic [IW-1:0] res_region;

    int total  = 0;
    int passed = 0;

    longint unsigned m_base [N];
    longint unsigned m_len  [N];
    int              m_attr [N];

    typedef struct {
        bit              lu;
        bit              we;
        int              idx;
        int              sel;
        longint unsigned d;
    } op_t;

    pma_region_table dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_sel_i(cfg_sel),
        .cfg_wdata_i(cfg_wdata), .cfg_ack_o(cfg_ack), .cfg_err_o(cfg_err), .cfg_rdata_o(cfg_rdata),
        .lu_valid_i(lu_valid), .lu_ready_o(lu_ready), .lu_addr_i(lu_addr),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_hit_o(res_hit),
        .res_region_o(res_region), .res_exec_o(res_exec), .res_cached_o(res_cached),
        .res_nonidem_o(res_nonidem)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_base[i] = 0; m_len[i] = 0; m_attr[i] = 0;
        end
        m_base[0] = 64'h8000_0000; m_len[0] = 64'h4000_0000; m_attr[0] = 3;
        m_base[1] = 64'h1_0000;    m_len[1] = 64'h1_0000;    m_attr[1] = 1;
        m_base[2] = 64'h0;         m_len[2] = 64'h1000;      m_attr[2] = 5;
    endfunction

    function automatic void model_lookup(input longint unsigned a, output bit hit, output int rg,
                                         output bit x, output bit c, output bit ni);
        hit = 0; rg = 0; x = 0; c = 0; ni = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_len[i] != 0 && a >= m_base[i] && a < m_base[i] + m_len[i]) begin
                hit = 1; rg = i;
                x = m_attr[i][0]; c = m_attr[i][1]; ni = m_attr[i][2];
            end
        end
    endfunction

    function automatic void model_cfg(input op_t op, output bit err, output longint unsigned rd);
        rd  = 0;
        err = (op.idx >= N) || (op.sel == 3);
        if (!err && op.we && m_attr[op.idx][3]) err = 1;
        if (!err) begin
            if (op.we) begin
                if (op.sel == 0) m_base[op.idx] = op.d & MASK;
                else if (op.sel == 1) m_len[op.idx] = op.d & MASK;
                else m_attr[op.idx] = int'(op.d & 15);
            end else begin
                rd = (op.sel == 0) ? m_base[op.idx] : (op.sel == 1) ? m_len[op.idx] : longint'(m_attr[op.idx]);
            end
        end
    endfunction

    function automatic op_t LU(input longint unsigned a);
        op_t o; o.lu = 1; o.we = 0; o.idx = 0; o.sel = 0; o.d = a & MASK; return o;
    endfunction
    function automatic op_t WR(input int idx, input int sel, input longint unsigned d);
        op_t o; o.lu = 0; o.we = 1; o.idx = idx; o.sel = sel; o.d = d & MASK; return o;
    endfunction
    function automatic op_t RD(input int idx, input int sel);
        op_t o; o.lu = 0; o.we = 0; o.idx = idx; o.sel = sel; o.d = 0; return o;
    endfunction

    task automatic cfg_xfer(input op_t op, output logic ack, output logic err, output logic [PW-1:0] rd);
        @(negedge clk);
        cfg_req = 1'b1; cfg_we = op.we; cfg_idx = 4'(op.idx); cfg_sel = 2'(op.sel); cfg_wdata = op.d[PW-1:0];
        @(negedge clk);
        ack = cfg_ack; err = cfg_err; rd = cfg_rdata;
        cfg_req = 1'b0;
    endtask

    task automatic lookup(input logic [PW-1:0] a, output logic got, output logic hit,
                          output logic [IW-1:0] rg, output logic x, output logic c,
                          output logic ni, output int lat);
        @(negedge clk);
        lu_valid = 1'b1; lu_addr = a; res_ready = 1'b1;
        @(negedge clk);
        lu_valid = 1'b0; lat = 1;
        while (!res_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        got = res_valid; hit = res_hit; rg = res_region; x = res_exec; c = res_cached; ni = res_nonidem;
    endtask

    task automatic apply_op(input string tag, input op_t op);
        bit ehit, ex, ec, eni, eerr;
        int ereg, lat;
        longint unsigned erd;
        logic got, hit, x, c, ni, ack, err;
        logic [IW-1:0] rg;
        logic [PW-1:0] rd;
        if (op.lu) begin
            model_lookup(op.d, ehit, ereg, ex, ec, eni);
            lookup(op.d[PW-1:0], got, hit, rg, x, c, ni, lat);
            total++;
            if (got !== 1'b1 || lat != 2 || hit !== ehit || rg !== IW'(ereg) || x !== ex || c !== ec || ni !== eni)
                $display("FAIL %s lookup %h: got v=%b lat=%0d hit=%b rg=%0d xcn=%b%b%b, expected v=1 lat=2 hit=%b rg=%0d xcn=%b%b%b",
                         tag, op.d, got, lat, hit, rg, x, c, ni, ehit, ereg, ex, ec, eni);
            else passed++;
        end else begin
            model_cfg(op, eerr, erd);
            cfg_xfer(op, ack, err, rd);
            total++;
            if (ack !== 1'b1 || err !== eerr || rd !== erd[PW-1:0])
                $display("FAIL %s cfg we=%0d idx=%0d sel=%0d: got ack=%b err=%b rd=%h, expected ack=1 err=%b rd=%h",
                         tag, op.we, op.idx, op.sel, ack, err, rd, eerr, erd[PW-1:0]);
            else passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({res_valid, res_hit, res_region, res_exec, res_cached, res_nonidem, cfg_ack, cfg_err} !== '0 || cfg_rdata !== '0)
            $display("FAIL reset_outputs: got res_valid=%b hit=%b ack=%b err=%b rdata=%h, expected all zero",
                     res_valid, res_hit, cfg_ack, cfg_err, cfg_rdata);
        else passed++;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (lu_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", lu_ready);
        else passed++;
        for (int i = 0; i < 4; i++)
            for (int s = 0; s < 3; s++) apply_op("reset_table", RD(i, s));
    endtask

    task automatic test_lookup_basic();
        longint unsigned addrs [7] = '{64'h8000_1000, 64'h800, 64'h2000_0000, 64'h1_8000,
                                       64'hBFFF_FFFF, 64'hC000_0000, 64'h1000};
        foreach (addrs[i]) apply_op("basic", LU(addrs[i]));
    endtask

    task automatic test_priority();
        op_t ops [7] = '{WR(3, 0, 64'h8000_0000), WR(3, 1, 64'h1000), WR(3, 2, 64'h4),
                         LU(64'h8000_0010), WR(0, 1, 0), LU(64'h8000_0010), LU(64'h8000_1000)};
        foreach (ops[i]) apply_op("priority", ops[i]);
    endtask

    task automatic test_lock();
        op_t ops [10] = '{WR(4, 2, 64'h9), WR(4, 0, 64'h1234), RD(4, 0), WR(4, 1, 64'h10),
                          WR(4, 2, 64'h0), RD(4, 2), RD(12, 0), RD(0, 3), WR(15, 0, 64'h5), RD(4, 1)};
        foreach (ops[i]) apply_op("lock", ops[i]);
    endtask

    task automatic test_top_of_space();
        op_t ops [8] = '{WR(5, 0, 64'h3_FFFF_F000), WR(5, 1, 64'h1000), WR(5, 2, 64'h3),
                         LU(64'h3_FFFF_FFFF), LU(64'h3_FFFF_F000), LU(64'h3_FFFF_EFFF), LU(64'h0), LU(64'hFFF)};
        foreach (ops[i]) apply_op("top_space", ops[i]);
    endtask

    task automatic test_same_cycle();
        bit eerr;
        longint unsigned erd;
        apply_op("same_cycle", WR(6, 0, 64'h2000_0000));
        apply_op("same_cycle", WR(6, 2, 64'h2));
        @(negedge clk);
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_idx = 4'd6; cfg_sel = 2'd1; cfg_wdata = 34'h100;
        lu_valid = 1'b1; lu_addr = 34'h2000_0010; res_ready = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0; lu_valid = 1'b0;
        total++;
        if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) $display("FAIL same_cycle_ack: got ack=%b err=%b expected 1 0", cfg_ack, cfg_err);
        else passed++;
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_hit !== 1'b0)
            $display("FAIL same_cycle_old_entry: got valid=%b hit=%b expected 1 0", res_valid, res_hit);
        else passed++;
        model_cfg(WR(6, 1, 64'h100), eerr, erd);
        apply_op("same_cycle_new", LU(64'h2000_0010));
    endtask

    task automatic test_back_to_back();
        longint unsigned addrs [6] = '{64'h8000_0000, 64'h800, 64'h2000_0000, 64'h1_0004,
                                       64'h3_FFFF_F800, 64'h2000_00FF};
        logic [7:0] exp_q [$];
        logic [7:0] cur, prev;
        bit ehit, ex, ec, eni, prev_hold, saw_stall;
        int ereg, sent, rcvd, cyc;
        sent = 0; rcvd = 0; cyc = 0; prev_hold = 0; saw_stall = 0; prev = '0;
        while ((sent < 6 || rcvd < 6) && cyc < 40) begin
            @(negedge clk);
            res_ready = !(cyc >= 3 && cyc <= 6);
            lu_valid  = (sent < 6);
            lu_addr   = (sent < 6) ? addrs[sent][PW-1:0] : '0;
            #1;
            cur = {res_hit, res_exec, res_cached, res_nonidem, 1'b0, res_region};
            if (prev_hold) begin
                total++;
                if (res_valid !== 1'b1 || cur !== prev)
                    $display("FAIL b2b_stable: got valid=%b out=%h, expected valid=1 out=%h", res_valid, cur, prev);
                else passed++;
            end
            if (lu_ready === 1'b0) saw_stall = 1;
            if (res_valid && res_ready) begin
                total++;
                if (exp_q.size() == 0 || cur !== exp_q[0])
                    $display("FAIL b2b_order: result %0d got %h, expected %h (queue %0d)", rcvd, cur,
                             (exp_q.size() != 0) ? exp_q[0] : 8'h0, exp_q.size());
                else passed++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                rcvd++;
            end
            if (lu_valid && lu_ready) begin
                model_lookup(addrs[sent], ehit, ereg, ex, ec, eni);
                exp_q.push_back({ehit, ex, ec, eni, 1'b0, 3'(ereg)});
                sent++;
            end
            prev_hold = res_valid && !res_ready;
            prev = cur;
            cyc++;
        end
        lu_valid = 1'b0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (sent != 6 || rcvd != 6 || !saw_stall || res_valid !== 1'b0)
            $display("FAIL b2b_count: got sent=%0d rcvd=%0d stall=%0d valid=%b, expected 6 6 1 0", sent, rcvd, saw_stall, res_valid);
        else passed++;
    endtask

    task automatic test_random();
        op_t op;
        int e;
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                e = $urandom_range(0, N - 1);
                case ($urandom_range(0, 3))
                    0: op = LU(m_base[e] + $urandom_range(0, 3));
                    1: op = LU(m_base[e] + m_len[e] - 1);
                    2: op = LU(m_base[e] + m_len[e]);
                    default: op = LU({$urandom, $urandom});
                endcase
            end else begin
                op.lu = 0; op.we = $urandom_range(0, 1); op.idx = $urandom_range(0, 9); op.sel = $urandom_range(0, 3);
                op.d = (op.sel == 1) ? longint'($urandom_range(0, 32'h2_0000)) : ({$urandom, $urandom} & MASK);
                if (op.sel == 2 && $urandom_range(0, 3) != 0) op.d = op.d & 7;
            end
            apply_op("random", op);
        end
    endtask

    task automatic test_reset_midflight();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        res_ready = 1'b0; lu_valid = 1'b1; lu_addr = 34'h8000_0000;
        @(negedge clk);
        lu_addr = 34'h800;
        @(negedge clk);
        lu_valid = 1'b0;
        #1;
        total++;
        if (res_valid !== 1'b1 || lu_ready !== 1'b0)
            $display("FAIL midflight_full: got valid=%b ready=%b expected 1 0", res_valid, lu_ready);
        else passed++;
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_idx = 4'd0; cfg_sel = 2'd0; cfg_wdata = 34'h1234;
        #1 rst = 1'b1;
        #1;
        total++;
        if (res_valid !== 1'b0 || cfg_ack !== 1'b0 || res_hit !== 1'b0)
            $display("FAIL midflight_reset: got valid=%b ack=%b hit=%b expected 0 0 0", res_valid, cfg_ack, res_hit);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        cfg_req = 1'b0; rst = 1'b0; res_ready = 1'b1;
        apply_op("midflight_table", RD(0, 0));
        apply_op("midflight_table", RD(5, 0));
        apply_op("midflight_table", LU(64'h8000_0000));
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lookup_basic();
        test_priority();
        test_lock();
        test_top_of_space();
        test_same_cycle();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
